// File: rtl/fmadd_align_normalize_seq.sv
// rtl/fmadd_align_normalize_seq.sv - iterative align/add/normalize stage of the FMADD addition path
//
// Purpose: takes two unpacked operands (sign, biased exponent, mantissa with
// hidden bit), aligns the smaller one with a one-bit-per-cycle sticky shifter,
// adds or subtracts, then normalizes one bit per cycle. The result (unrounded
// mantissa, widened exponent, sign, guard/round/sticky) feeds the rounder.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       operand handshake; in_ready is high only when idle
//   a_sign, a_exp, a_man      operand A (hidden bit at a_man[man+1])
//   b_sign, b_exp, b_man      operand B, sign already flipped for subtract
//   out_valid / out_ready     result handshake; result held until accepted
//   out_mantissa              normalized mantissa with hidden bit
//   out_exponent              exponent with one extra MSB for overflow
//   out_sign                  result sign
//   out_guard/round/sticky    bits below the mantissa LSB

module fmadd_align_normalize_seq #(
  parameter int man = 22,
  parameter int exp = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_sign,
  input  logic [exp:0]     a_exp,
  input  logic [man+1:0]   a_man,
  input  logic             b_sign,
  input  logic [exp:0]     b_exp,
  input  logic [man+1:0]   b_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [man+1:0]   out_mantissa,
  output logic [exp+1:0]   out_exponent,
  output logic             out_sign,
  output logic             out_guard,
  output logic             out_round,
  output logic             out_sticky
);

  // Extended working width: mantissa plus guard, round and sticky.
  localparam int W = man + 5;
  // Beyond this distance every small-operand bit lands below the round bit,
  // so only its sticky contribution survives.
  localparam logic [exp:0] DIFF_CAP = (exp + 1)'(man + 4);
  localparam logic [exp+1:0] EXP_ONE = (exp + 2)'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [W-1:0]   large_ext;
  logic [W-1:0]   small_ext;
  logic [exp:0]   diff;
  logic           large_sign;
  logic           small_sign;
  logic [exp:0]   large_exp;
  logic [W:0]     res;
  logic [exp+1:0] res_exp;
  logic           res_sign;

  // Operand ordering: bigger exponent wins, then bigger mantissa, A on a tie.
  // This keeps large - small non-negative for normalized inputs.
  logic           swap;
  logic           sel_large_sign;
  logic           sel_small_sign;
  logic [exp:0]   sel_large_exp;
  logic [exp:0]   sel_small_exp;
  logic [man+1:0] sel_large_man;
  logic [man+1:0] sel_small_man;
  logic [exp:0]   in_diff;
  logic           diff_capped;

  always_comb begin
    swap           = (b_exp > a_exp) || ((b_exp == a_exp) && (b_man > a_man));
    sel_large_sign = swap ? b_sign : a_sign;
    sel_small_sign = swap ? a_sign : b_sign;
    sel_large_exp  = swap ? b_exp  : a_exp;
    sel_small_exp  = swap ? a_exp  : b_exp;
    sel_large_man  = swap ? b_man  : a_man;
    sel_small_man  = swap ? a_man  : b_man;
    in_diff        = sel_large_exp - sel_small_exp;
    diff_capped    = (in_diff >= DIFF_CAP);
  end

  // Normalization is finished when the result is zero, or when there is no
  // pending carry and either the hidden bit is set or the exponent has hit
  // the subnormal floor.
  logic norm_finished;

  always_comb begin
    norm_finished = (res == '0) ||
                    (!res[W] && (res[W-1] || (res_exp <= EXP_ONE)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)      state_next = ALIGN;
      ALIGN:   if (diff == '0)    state_next = ADD;
      ADD:                        state_next = NORM;
      NORM:    if (norm_finished) state_next = DONE;
      DONE:    if (out_ready)     state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      large_ext  <= '0;
      small_ext  <= '0;
      diff       <= '0;
      large_sign <= 1'b0;
      small_sign <= 1'b0;
      large_exp  <= '0;
      res        <= '0;
      res_exp    <= '0;
      res_sign   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            large_sign <= sel_large_sign;
            small_sign <= sel_small_sign;
            large_exp  <= sel_large_exp;
            large_ext  <= {sel_large_man, 3'b000};
            if (diff_capped) begin
              small_ext <= {{(W-1){1'b0}}, |sel_small_man};
              diff      <= '0;
            end else begin
              small_ext <= {sel_small_man, 3'b000};
              diff      <= in_diff;
            end
          end
        end

        ALIGN: begin
          // Right shift by one, folding the two lowest bits into sticky.
          if (diff != '0) begin
            small_ext <= {1'b0, small_ext[W-1:2], small_ext[1] | small_ext[0]};
            diff      <= diff - 1'b1;
          end
        end

        ADD: begin
          if (large_sign == small_sign) begin
            res <= {1'b0, large_ext} + {1'b0, small_ext};
          end else begin
            res <= {1'b0, large_ext} - {1'b0, small_ext};
          end
          res_sign <= large_sign;
          res_exp  <= {1'b0, large_exp};
        end

        NORM: begin
          if (res == '0) begin
            // Exact cancellation yields +0.
            res_exp  <= '0;
            res_sign <= 1'b0;
          end else if (res[W]) begin
            res     <= {1'b0, res[W:2], res[1] | res[0]};
            res_exp <= res_exp + 1'b1;
          end else if (res[W-1]) begin
            res <= res;
          end else if (res_exp <= EXP_ONE) begin
            // Subnormal: stop shifting, the rounder zeroes the exponent.
            res <= res;
          end else begin
            res     <= {res[W-1:0], 1'b0};
            res_exp <= res_exp - 1'b1;
          end
        end

        default: begin
          res <= res;
        end
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign out_mantissa = res[W-1:3];
  assign out_exponent = res_exp;
  assign out_sign     = res_sign;
  assign out_guard    = res[2];
  assign out_round    = res[1];
  assign out_sticky   = res[0];

endmodule

// File: doc/fmadd_align_normalize_seq.md
Name: fmadd_align_normalize_seq

Overview:
- Multi-cycle alignment, add/subtract and normalization unit for the FMADD addition path.
- Sits directly upstream of the addition rounding block. Produces exactly that block's inputs: unrounded mantissa with hidden bit, 9-bit exponent, sign, and guard/round/sticky.
- Processes one operation at a time under a valid/ready handshake. Shifting is iterative, one bit per cycle, to save area.

Parameters:
- man, 22, mantissa MSB index; stored fraction is man+1 bits. bfloat16 uses 6.
- exp, 7, exponent MSB index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit idle, can accept
- a_sign  in  1  effective sign A
- a_exp  in  exp+1  biased exponent A
- a_man  in  man+2  mantissa A, hidden bit at [man+1]
- b_sign  in  1  effective sign B, already adjusted for subtract
- b_exp  in  exp+1  biased exponent B
- b_man  in  man+2  mantissa B, hidden bit at [man+1]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_mantissa  out  man+2  normalized unrounded mantissa
- out_exponent  out  exp+2  exponent, extra MSB exposes overflow (0x0FF)
- out_sign  out  1  result sign
- out_guard, out_round, out_sticky  out  1 each  GRS bits

Behaviour:
- Reset: state IDLE. out_valid=0, all data outputs 0, in_ready=1 in the cycle after reset. Reset in any state abandons the operation; no output is produced.
- in_ready = (state==IDLE), combinational. Only one operation is in flight.
- Working extended width is W = man+5: {mantissa[man+1:0], G, R, S}.
- Result mantissa register is W+1 bits, including a carry bit.
- IDLE, when in_valid is high:
  - Capture operands. Large = operand with greater exponent; on equal exponents, greater mantissa; on full tie, A.
  - large_ext = {large_man, 000}; small_ext = {small_man, 000}; diff = large_exp - small_exp.
  - If diff >= man+4, replace small_ext with all zeros except S = |small_man, and set diff=0.
  - Go ALIGN.
- ALIGN, each cycle:
  - If diff==0, go ADD.
  - Otherwise small_ext = {0, small_ext[W-1:2], small_ext[1]|small_ext[0]} and diff decrements.
  - ALIGN lasts diff+1 cycles, or 1 cycle when capped.
- ADD, 1 cycle:
  - If signs are equal: res = large_ext + small_ext. Otherwise: res = large_ext - small_ext, which is never negative.
  - sign = large sign. Exponent register = {0, large_exp}.
  - Go NORM.
- NORM, one action per cycle, priority order:
  1. res==0: force exponent=0, sign=0, go DONE.
  2. Carry bit set: shift right 1 with sticky OR, exponent+1.
  3. Hidden bit set: go DONE.
  4. exponent<=1: go DONE. Subnormal; the rounding block zeroes the exponent.
  5. Otherwise: shift left 1 inserting 0, exponent-1.
- DONE:
  - out_valid=1. Outputs are driven from registers: out_mantissa = res[W-1:3], G/R/S = res[2:0].
  - Outputs stay stable while out_ready=0.
  - On out_valid & out_ready, go IDLE. out_valid falls in the next cycle; in_ready rises in the same cycle.
- Exponent arithmetic is exp+2 bits wide. A carry-normalize to 0x0FF is passed through unchanged; overflow flagging belongs downstream.
- in_valid is ignored outside IDLE. The output handshake is not combinationally coupled to in_valid.

Test Plan:
- man=22, A=B=1.0 (exp 127, man 0x800000, both signs 0), out_ready=1 -> accept at edge 0, ALIGN 1, ADD 1, NORM 2 cycles, out_valid in 5th cycle. Result: mantissa 0x800000, exponent 0x080, G=R=S=0, sign 0.
- A=1.0 (sign 0), B: exp 127, man 0xC00000, sign 1 -> large=B, one left shift. Result: mantissa 0x800000, exponent 0x07E, sign 1, GRS=000.
- A=1.0, B: exp 103, man 0x800000, same sign -> 24 ALIGN shifts (25 cycles). Result: mantissa 0x800000, exponent 0x07F, G=1, R=0, S=0 (tie case).
- A=1.0, B: exp 100, man 0xC00000 -> diff 27 capped, ALIGN 1 cycle. Result: mantissa 0x800000, exponent 0x07F, GRS=001.
- A=1.0 minus B=1.0 (opposite signs) -> mantissa 0, exponent 0, sign 0, GRS=000.
- Back-pressure: hold out_ready=0 for 3 cycles in DONE -> outputs constant, in_ready=0. A new in_valid during this time is ignored. Separately, assert rst mid-ALIGN -> next cycle in_ready=1, out_valid=0, and no result ever appears.
